// File: rtl/pll_lock_sequencer_if.sv
// Handshake bundle between the PLL lock sequencer and its surroundings.
// The slave side is the sequencer; the master side drives lock and switch requests.
interface pll_lock_sequencer_if;
   logic       pll_locked_i;
   logic       sw_req_i;
   logic       cfg_sel_o;
   logic       sys_rst_o;
   logic       clk_en_o;
   logic [2:0] state_o;
   logic [7:0] lock_loss_cnt_o;
   logic       fail_o;

   modport master (
      output pll_locked_i,
      output sw_req_i,
      input  cfg_sel_o,
      input  sys_rst_o,
      input  clk_en_o,
      input  state_o,
      input  lock_loss_cnt_o,
      input  fail_o
   );

   modport slave (
      input  pll_locked_i,
      input  sw_req_i,
      output cfg_sel_o,
      output sys_rst_o,
      output clk_en_o,
      output state_o,
      output lock_loss_cnt_o,
      output fail_o
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Qualifies PLL lock, retries the alternate configuration set on timeout and
// sequences the downstream reset/clock enable. Runs from the PLL reference clock.
module pll_lock_sequencer #(
   parameter int SETTLE_CYCLES = 64,
   parameter int LOCK_TIMEOUT  = 1024,
   parameter int MAX_RETRY     = 3,
   parameter bit CFG_INIT      = 1'b0,
   parameter int CNT_W         = 16
) (
   input logic                 CLK_REF,
   input logic                 USR_LOCKED_STDY_RST,
   pll_lock_sequencer_if.slave bus
);

   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_SETTLE    = 3'd2,
      S_RUN       = 3'd3,
      S_SWITCH    = 3'd4,
      S_FAIL      = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               cfgSel_q, cfgSel_d;
   logic [7:0]         lossCnt_q, lossCnt_d;
   logic               fail_q, fail_d;
   logic               sysRst_q, sysRst_d;
   logic               clkEn_q, clkEn_d;

   always_ff @(posedge CLK_REF or posedge USR_LOCKED_STDY_RST) begin
      if (USR_LOCKED_STDY_RST) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         retry_q   <= '0;
         cfgSel_q  <= CFG_INIT;
         lossCnt_q <= '0;
         fail_q    <= 1'b0;
         sysRst_q  <= 1'b1;
         clkEn_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         retry_q   <= retry_d;
         cfgSel_q  <= cfgSel_d;
         lossCnt_q <= lossCnt_d;
         fail_q    <= fail_d;
         sysRst_q  <= sysRst_d;
         clkEn_q   <= clkEn_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      retry_d   = retry_q;
      cfgSel_d  = cfgSel_q;
      lossCnt_d = lossCnt_q;
      fail_d    = fail_q;

      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            retry_d = '0;
            state_d = S_WAIT_LOCK;
         end

         // Lock wins over a timeout landing on the same cycle.
         S_WAIT_LOCK: begin
            if (bus.pll_locked_i) begin
               state_d = S_SETTLE;
               timer_d = '0;
            end else if (timer_q == TIMEOUT_LAST) begin
               if (retry_q < RETRY_LIMIT) begin
                  state_d  = S_SWITCH;
                  cfgSel_d = ~cfgSel_q;
                  retry_d  = retry_q + 1'b1;
               end else begin
                  state_d = S_FAIL;
                  fail_d  = 1'b1;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         S_SETTLE: begin
            if (!bus.pll_locked_i) begin
               state_d = S_WAIT_LOCK;
               timer_d = '0;
            end else if (timer_q == SETTLE_LAST) begin
               state_d = S_RUN;
               timer_d = '0;
               retry_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         // A user-requested switch is not a retry, so retry stays at zero.
         S_RUN: begin
            retry_d = '0;
            if (!bus.pll_locked_i) begin
               state_d = S_WAIT_LOCK;
               timer_d = '0;
               if (lossCnt_q != 8'hFF) begin
                  lossCnt_d = lossCnt_q + 8'd1;
               end
            end else if (bus.sw_req_i) begin
               state_d  = S_SWITCH;
               cfgSel_d = ~cfgSel_q;
            end
         end

         S_SWITCH: begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
         end

         S_FAIL: begin
            state_d = S_FAIL;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      sysRst_d = (state_d != S_RUN);
      clkEn_d  = (state_d == S_RUN);
   end

   assign bus.cfg_sel_o       = cfgSel_q;
   assign bus.sys_rst_o       = sysRst_q;
   assign bus.clk_en_o        = clkEn_q;
   assign bus.state_o         = state_q;
   assign bus.lock_loss_cnt_o = lossCnt_q;
   assign bus.fail_o          = fail_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: a per-edge vector table plus
// hand-written sequences for retry clearing, saturation and async reset.
module tb_pll_lock_sequencer;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WAIT   = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_RUN    = 3'd3;
   localparam logic [2:0] ST_SWITCH = 3'd4;
   localparam logic [2:0] ST_FAIL   = 3'd5;

   typedef struct {
      logic       locked;
      logic       swReq;
      logic [2:0] expState;
      logic       expCfg;
      logic [7:0] expCnt;
      logic       expFail;
   } vec_t;

   vec_t vecs[$];

   logic refClock = 1'b0;
   logic rstLine  = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   pll_lock_sequencer_if bus();

   pll_lock_sequencer #(
      .SETTLE_CYCLES(8),
      .LOCK_TIMEOUT (32),
      .MAX_RETRY    (2),
      .CFG_INIT     (1'b0),
      .CNT_W        (16)
   ) dut (
      .CLK_REF            (refClock),
      .USR_LOCKED_STDY_RST(rstLine),
      .bus                (bus)
   );

   always #5 refClock = ~refClock;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic addVec(input int n, input logic l, input logic sw, input logic [2:0] st,
                         input logic cfg, input logic [7:0] cnt, input logic fl);
      vec_t v;
      v.locked   = l;
      v.swReq    = sw;
      v.expState = st;
      v.expCfg   = cfg;
      v.expCnt   = cnt;
      v.expFail  = fl;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic checkField(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic [2:0] st, input logic cfg,
                              input logic [7:0] cnt, input logic fl);
      checkField({name, ".state"},   bus.state_o,         st);
      checkField({name, ".cfgSel"},  bus.cfg_sel_o,       cfg);
      checkField({name, ".lossCnt"}, bus.lock_loss_cnt_o, cnt);
      checkField({name, ".fail"},    bus.fail_o,          fl);
      checkField({name, ".sysRst"},  bus.sys_rst_o,       (st != ST_RUN));
      checkField({name, ".clkEn"},   bus.clk_en_o,        (st == ST_RUN));
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 unit after the rising edge.
   task automatic applyStimulus(input logic l, input logic sw);
      @(negedge refClock);
      bus.pll_locked_i = l;
      bus.sw_req_i     = sw;
      @(posedge refClock);
      #1;
   endtask

   task automatic startFromReset(input string name);
      @(negedge refClock);
      rstLine          = 1'b1;
      bus.pll_locked_i = 1'b0;
      bus.sw_req_i     = 1'b0;
      @(negedge refClock);
      checkOutput(name, ST_IDLE, 1'b0, 8'd0, 1'b0);
      @(posedge refClock);
      #2 rstLine = 1'b0;
   endtask

   initial begin
      int  switches;
      bit  reachedFail;

      bus.pll_locked_i = 1'b0;
      bus.sw_req_i     = 1'b0;

      // Acquisition, RUN lock loss, user switch, then three timeouts into FAIL.
      addVec(5, 1'b0, 1'b0, ST_WAIT,   1'b0, 8'd0, 1'b0);
      addVec(8, 1'b1, 1'b0, ST_SETTLE, 1'b0, 8'd0, 1'b0);
      addVec(1, 1'b1, 1'b0, ST_RUN,    1'b0, 8'd0, 1'b0);
      addVec(3, 1'b0, 1'b0, ST_WAIT,   1'b0, 8'd1, 1'b0);
      addVec(8, 1'b1, 1'b0, ST_SETTLE, 1'b0, 8'd1, 1'b0);
      addVec(1, 1'b1, 1'b0, ST_RUN,    1'b0, 8'd1, 1'b0);
      addVec(1, 1'b1, 1'b1, ST_SWITCH, 1'b1, 8'd1, 1'b0);
      addVec(1, 1'b1, 1'b0, ST_WAIT,   1'b1, 8'd1, 1'b0);
      addVec(1, 1'b1, 1'b0, ST_SETTLE, 1'b1, 8'd1, 1'b0);
      addVec(1, 1'b1, 1'b1, ST_SETTLE, 1'b1, 8'd1, 1'b0);
      addVec(6, 1'b1, 1'b0, ST_SETTLE, 1'b1, 8'd1, 1'b0);
      addVec(1, 1'b1, 1'b0, ST_RUN,    1'b1, 8'd1, 1'b0);
      addVec(32, 1'b0, 1'b0, ST_WAIT,  1'b1, 8'd2, 1'b0);
      addVec(1, 1'b0, 1'b0, ST_SWITCH, 1'b0, 8'd2, 1'b0);
      addVec(32, 1'b0, 1'b0, ST_WAIT,  1'b0, 8'd2, 1'b0);
      addVec(1, 1'b0, 1'b0, ST_SWITCH, 1'b1, 8'd2, 1'b0);
      addVec(32, 1'b0, 1'b0, ST_WAIT,  1'b1, 8'd2, 1'b0);
      addVec(1, 1'b0, 1'b0, ST_FAIL,   1'b1, 8'd2, 1'b1);
      addVec(4, 1'b1, 1'b1, ST_FAIL,   1'b1, 8'd2, 1'b1);

      startFromReset("resetA");
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].locked, vecs[i].swReq);
         checkOutput($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expCfg,
                     vecs[i].expCnt, vecs[i].expFail);
      end

      // Pure timeout from reset: first switch lands on edge 33.
      startFromReset("resetT");
      repeat (32) applyStimulus(1'b0, 1'b0);
      checkOutput("timeoutPre", ST_WAIT, 1'b0, 8'd0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("timeoutSwitch", ST_SWITCH, 1'b1, 8'd0, 1'b0);

      // Lock drops at settle count 5; a fresh run of 8 locked cycles is needed.
      startFromReset("resetB");
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("settleEnter", ST_SETTLE, 1'b0, 8'd0, 1'b0);
      repeat (5) applyStimulus(1'b1, 1'b0);
      checkOutput("settleCnt5", ST_SETTLE, 1'b0, 8'd0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("settleDrop", ST_WAIT, 1'b0, 8'd0, 1'b0);
      repeat (8) applyStimulus(1'b1, 1'b0);
      checkOutput("settleFresh7", ST_SETTLE, 1'b0, 8'd0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("settleRun", ST_RUN, 1'b0, 8'd0, 1'b0);

      // One timeout consumes a retry; reaching RUN must restore the full budget.
      repeat (33) applyStimulus(1'b0, 1'b0);
      checkOutput("retrySwitch", ST_SWITCH, 1'b1, 8'd1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      repeat (8) applyStimulus(1'b1, 1'b0);
      checkOutput("retrySettle", ST_SETTLE, 1'b1, 8'd1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("retryRun", ST_RUN, 1'b1, 8'd1, 1'b0);
      switches    = 0;
      reachedFail = 1'b0;
      for (int i = 0; i < 200 && !reachedFail; i++) begin
         applyStimulus(1'b0, 1'b0);
         if (bus.state_o == ST_SWITCH) switches++;
         if (bus.state_o == ST_FAIL)   reachedFail = 1'b1;
      end
      checkField("retryReachedFail", reachedFail, 1);
      checkField("retrySwitchCount", switches, 2);

      // 256 lock losses saturate the counter, then reset mid-SETTLE with cfg_sel=1.
      startFromReset("resetC");
      applyStimulus(1'b0, 1'b0);
      repeat (9) applyStimulus(1'b1, 1'b0);
      checkOutput("satRun0", ST_RUN, 1'b0, 8'd0, 1'b0);
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b0, 1'b0);
         repeat (9) applyStimulus(1'b1, 1'b0);
         if (i == 253) checkOutput("satCnt254", ST_RUN, 1'b0, 8'd254, 1'b0);
      end
      checkOutput("satCnt255", ST_RUN, 1'b0, 8'd255, 1'b0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("satSwitch", ST_SWITCH, 1'b1, 8'd255, 1'b0);
      applyStimulus(1'b1, 1'b0);
      repeat (3) applyStimulus(1'b1, 1'b0);
      checkOutput("satSettle", ST_SETTLE, 1'b1, 8'd255, 1'b0);
      #2 rstLine = 1'b1;
      #1;
      checkOutput("asyncReset", ST_IDLE, 1'b0, 8'd0, 1'b0);
      @(posedge refClock);
      #1;
      checkOutput("resetHeld", ST_IDLE, 1'b0, 8'd0, 1'b0);
      #2 rstLine = 1'b0;
      applyStimulus(1'b1, 1'b0);
      checkOutput("postReset", ST_WAIT, 1'b0, 8'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Supervises a CC_PLL instance.
- Qualifies its lock indication and drives the PLL configuration-set select (USR_SET_SEL).
- Retries the alternate configuration set when lock times out, and sequences the downstream system reset and clock enable.
- Sits between the PLL and the fabric reset tree. It is clocked from the PLL reference clock so it runs before any PLL output clock exists.

Parameters:
- SETTLE_CYCLES, 64, consecutive locked cycles required before release (≥1).
- LOCK_TIMEOUT, 1024, WAIT_LOCK cycles allowed before declaring timeout (≥2).
- MAX_RETRY, 3, configuration switches allowed per acquisition attempt before FAIL (≥0).
- CFG_INIT, 0, cfg_sel_o value at reset.
- CNT_W, 16, width of the settle/timeout timer; must hold max(SETTLE_CYCLES, LOCK_TIMEOUT).

Ports:
- CLK_REF  in  1  reference clock; also the sequencer clock.
- USR_LOCKED_STDY_RST  in  1  reset, asynchronous, active-high.
- pll_locked_i  in  1  PLL USR_PLL_LOCKED; already synchronous to CLK_REF.
- sw_req_i  in  1  single-cycle request to switch configuration set; honoured only in RUN.
- cfg_sel_o  out  1  to PLL USR_SET_SEL.
- sys_rst_o  out  1  active-high downstream reset.
- clk_en_o  out  1  downstream clock enable.
- state_o  out  3  current state encoding.
- lock_loss_cnt_o  out  8  saturating count of lock losses seen in RUN.
- fail_o  out  1  sticky: retries exhausted.

Behaviour:
- **Reset values:** state=IDLE; sys_rst_o=1; clk_en_o=0; cfg_sel_o=CFG_INIT; lock_loss_cnt_o=0; fail_o=0; timer=0; retry=0.
- **Output registration:** all outputs are registered.
  - sys_rst_o=0 and clk_en_o=1 only while state=RUN; both are Moore-decoded from the state register.
- **State encoding:** IDLE=0, WAIT_LOCK=1, SETTLE=2, RUN=3, SWITCH=4, FAIL=5.
- **IDLE:**
  - Unconditionally goes to WAIT_LOCK on the first edge after reset deassertion.
  - Clears timer and retry.
- **WAIT_LOCK:**
  - timer increments each cycle.
  - pll_locked_i=1 → SETTLE with timer cleared. Lock has priority over timeout in the same cycle.
  - Else if timer==LOCK_TIMEOUT-1:
    - retry<MAX_RETRY → SWITCH;
    - otherwise → FAIL.
- **SETTLE:**
  - Each cycle with pll_locked_i=1 increments timer.
  - When timer==SETTLE_CYCLES-1 and pll_locked_i=1 → RUN.
  - Any cycle with pll_locked_i=0 → WAIT_LOCK with timer cleared. retry is not incremented.
  - Release latency: the edge that first samples lock moves WAIT_LOCK→SETTLE (edge t). RUN is entered at edge t+SETTLE_CYCLES; sys_rst_o falls and clk_en_o rises on that same edge.
- **RUN:**
  - On entry, clears retry.
  - pll_locked_i=0 → WAIT_LOCK. On the same edge: lock_loss_cnt_o increments, saturating at 255, and timer is cleared.
  - Else sw_req_i=1 → SWITCH. Lock loss has priority over sw_req_i.
- **SWITCH:**
  - Lasts exactly one cycle.
  - cfg_sel_o toggles on the edge entering SWITCH.
  - retry increments on entry, except when entered from RUN via sw_req_i, where retry stays 0.
  - Next state WAIT_LOCK with timer cleared.
- **FAIL:**
  - Terminal until reset.
  - fail_o=1 from the edge entering FAIL; sys_rst_o=1, clk_en_o=0; cfg_sel_o holds.
- **sw_req_i outside RUN:** ignored; it is not queued.
- **Mid-operation reset:** asynchronously forces all reset values, including cfg_sel_o back to CFG_INIT. No partial state survives.
- **Glitch exposure:** clk_en_o never rises without sys_rst_o falling on the same edge.

Test Plan:
(Bench parameters: SETTLE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRY=2, CFG_INIT=0.)
1. Reset released, pll_locked_i rises at cycle 5 and stays high → SETTLE sampled at edge 6. RUN/sys_rst_o=0/clk_en_o=1 at edge 14. cfg_sel_o stays 0.
2. Lock drops for 1 cycle during SETTLE at settle count 5 → return to WAIT_LOCK, timer restarts. RUN only after 8 fresh consecutive locked cycles; lock_loss_cnt_o stays 0.
3. pll_locked_i held 0 → SWITCH at cycle 33 (cfg_sel_o=1) and again 33 cycles later (cfg_sel_o=0). After the third timeout: FAIL, fail_o=1, state_o=5, sys_rst_o=1. Held until reset.
4. In RUN, drop pll_locked_i for 3 cycles then restore → sys_rst_o=1/clk_en_o=0 one edge after the drop; lock_loss_cnt_o=1. RUN again 8 locked cycles after re-lock.
5. In RUN, pulse sw_req_i → SWITCH for 1 cycle with cfg_sel_o toggled, then WAIT_LOCK. Re-lock reaches RUN with retry=0. sw_req_i pulsed in SETTLE is ignored.
6. Assert USR_LOCKED_STDY_RST mid-SETTLE with cfg_sel_o=1, and 256 lock losses before it → immediate IDLE outputs, cfg_sel_o=0, lock_loss_cnt_o=0. Before reset, the counter is verified saturated at 255.
